// File: rtl/prog_mem_loader_pkg.sv
// Shared types for the cpu_4bit program loader: instruction word, loader FSM states, NOP encoding.
package prog_mem_loader_pkg;

  typedef logic [7:0] instruction_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    RUN,
    ERROR
  } loader_state_t;

  localparam instruction_t INSTR_NOP = '0;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Host-side program load stream: start pulse, valid/ready word transfer, and completion status.
interface prog_mem_loader_if;
  import prog_mem_loader_pkg::*;

  logic         load_start;
  logic         load_valid;
  instruction_t load_data;
  logic         load_last;
  logic         load_ready;
  logic         load_done;
  logic         load_error;

  modport master (
    output load_start, load_valid, load_data, load_last,
    input  load_ready, load_done, load_error
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    output load_ready, load_done, load_error
  );

endinterface

// File: rtl/prog_mem_loader_instr_store.sv
// DEPTH-word instruction register array: one sync write port, sync clear-all, combinational read.
module instr_store
  import prog_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  instruction_t      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output instruction_t      rdata
);

  instruction_t mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clk) begin
      if (clr)
        mem[g] <= INSTR_NOP;
      else if (we && waddr == ADDR_W'(g))
        mem[g] <= wdata;
    end
  end

  // Address compare mux keeps the read legal for any DEPTH up to 2**ADDR_W.
  always_comb begin
    rdata = INSTR_NOP;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == ADDR_W'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction-side responder for cpu_4bit: host-loaded program store, holds the CPU until commit.
// Optional CHECKSUM_EN: trailing XOR checksum word gates the commit (CHK/ERROR states, sticky load_error).
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  instruction_addr,
  output instruction_t       instruction,
  output logic               cpu_run,
  prog_mem_loader_if.slave   ld
);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic              done_q, done_nxt;
  logic              rdy, xfer, last_wr, we, store_clr;
  instruction_t      store_rdata;
`ifdef CHECKSUM_EN
  instruction_t      csum, csum_nxt;
  logic              err_q, err_nxt;
`endif

  assign rdy     = (state == LOAD) || (state == CHK);
  // A start pulse owns the cycle: any word presented alongside it is dropped.
  assign xfer    = ld.load_valid & rdy & ~ld.load_start;
  assign last_wr = xfer & (state == LOAD) &
                   (ld.load_last | (wr_ptr == ADDR_W'(DEPTH - 1)));

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    done_nxt   = 1'b0;
    we         = 1'b0;
`ifdef CHECKSUM_EN
    csum_nxt   = csum;
    err_nxt    = err_q;
`endif
    if (ld.load_start) begin
      state_nxt  = LOAD;
      wr_ptr_nxt = '0;
`ifdef CHECKSUM_EN
      csum_nxt   = INSTR_NOP;
      err_nxt    = 1'b0;
`endif
    end else begin
      case (state)
        LOAD: if (xfer) begin
          we = 1'b1;
`ifdef CHECKSUM_EN
          csum_nxt = csum ^ ld.load_data;
`endif
          if (last_wr) begin
`ifdef CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = RUN;
            done_nxt  = 1'b1;
`endif
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        CHK: if (xfer) begin
          if (ld.load_data == csum) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      done_q <= 1'b0;
`ifdef CHECKSUM_EN
      csum   <= INSTR_NOP;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      done_q <= done_nxt;
`ifdef CHECKSUM_EN
      csum   <= csum_nxt;
      err_q  <= err_nxt;
`endif
    end
  end

  assign store_clr = ~reset | ld.load_start;

  instr_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_store (
    .clk   (clk),
    .clr   (store_clr),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (ld.load_data),
    .raddr (instruction_addr),
    .rdata (store_rdata)
  );

  assign cpu_run       = (state == RUN);
  assign ld.load_ready = rdy;
  assign ld.load_done  = done_q;
`ifdef CHECKSUM_EN
  assign ld.load_error = err_q;
`else
  assign ld.load_error = 1'b0;
`endif

  assign instruction = (cpu_run && int'(instruction_addr) < DEPTH) ? store_rdata : INSTR_NOP;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: queue-based program model checked every cycle plus literal spot checks.
module tb_prog_mem_loader;
  import prog_mem_loader_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   instruction_addr = '0;
  instruction_t instruction;
  logic         cpu_run;

  prog_mem_loader_if bus();

  prog_mem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_addr (instruction_addr),
    .instruction      (instruction),
    .cpu_run          (cpu_run),
    .ld               (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words accepted so far; the program becomes visible only once the phase reaches M_RUN.
  typedef enum {M_IDLE, M_COLLECT, M_SUM, M_RUN, M_ERR} mphase_t;
  mphase_t      m_ph = M_IDLE;
  instruction_t m_words[$];
  bit           m_done = 1'b0;
  bit           m_err  = 1'b0;

  function automatic instruction_t m_xor();
    instruction_t x = '0;
    foreach (m_words[i]) x ^= m_words[i];
    return x;
  endfunction

  function automatic instruction_t m_fetch(input logic [3:0] a);
    if (m_ph == M_RUN && int'(a) < m_words.size()) return m_words[a];
    return '0;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!reset) begin
      m_ph = M_IDLE; m_words.delete(); m_err = 1'b0;
    end else if (bus.load_start) begin
      m_ph = M_COLLECT; m_words.delete(); m_err = 1'b0;
    end else if (bus.load_valid) begin
      if (m_ph == M_COLLECT) begin
        m_words.push_back(bus.load_data);
        if (bus.load_last || m_words.size() == 16) begin
`ifdef CHECKSUM_EN
          m_ph = M_SUM;
`else
          m_ph = M_RUN; m_done = 1'b1;
`endif
        end
      end else if (m_ph == M_SUM) begin
        if (bus.load_data == m_xor()) begin m_ph = M_RUN; m_done = 1'b1; end
        else begin m_ph = M_ERR; m_err = 1'b1; end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cpu_run", cpu_run, m_ph == M_RUN);
    chk("load_ready", bus.load_ready, (m_ph == M_COLLECT) || (m_ph == M_SUM));
    chk("load_done", bus.load_done, m_done);
    chk("load_error", bus.load_error, m_err);
    chk("instruction", instruction, m_fetch(instruction_addr));
  end

  // Caller sits at a negedge; inputs are consumed by the next posedge, returns at the following negedge.
  task automatic step(input bit s, input bit v, input instruction_t d, input bit l);
    bus.load_start = s; bus.load_valid = v; bus.load_data = d; bus.load_last = l;
    @(negedge clk);
  endtask

  task automatic peek(input logic [3:0] a, output instruction_t q);
    instruction_addr = a;
    #1;
    q = instruction;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instruction_t q;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_ready", bus.load_ready, 0);
    for (int a = 0; a < 16; a++) begin
      peek(4'(a), q);
      chk("rst_instr", q, 0);
    end
    reset = 1'b1;

    // Word offered while idle is ignored
    step(0, 1, 8'h33, 1);
    chk("idle_ignore_run", cpu_run, 0);

    // Three-word program
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 1);
`ifdef CHECKSUM_EN
    step(0, 1, 8'h00, 0);
`endif
    chk("p3_done", bus.load_done, 1);
    chk("p3_run", cpu_run, 1);
    step(0, 0, 8'h00, 0);
    chk("p3_done_pulse", bus.load_done, 0);
    peek(4'd0, q); chk("p3_a0", q, 8'h01);
    peek(4'd1, q); chk("p3_a1", q, 8'h02);
    peek(4'd2, q); chk("p3_a2", q, 8'h03);
    peek(4'd3, q); chk("p3_a3", q, 8'h00);

    // Sixteen words, no load_last: implicit commit, trailing word ignored
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h10 + i), 0);
`ifdef CHECKSUM_EN
    step(0, 1, 8'h00, 0);
`endif
    chk("p16_done", bus.load_done, 1);
    chk("p16_run", cpu_run, 1);
    step(0, 1, 8'hAA, 1);
    chk("p16_post_ignored", bus.load_done, 0);
    peek(4'd0, q);  chk("p16_a0", q, 8'h10);
    peek(4'd15, q); chk("p16_a15", q, 8'h1F);

    // load_start with load_valid in RUN: word dropped, store cleared
    step(1, 1, 8'h55, 0);
    chk("restart_run", cpu_run, 0);
    chk("restart_ready", bus.load_ready, 1);
    step(0, 1, 8'h07, 1);
`ifdef CHECKSUM_EN
    step(0, 1, 8'h07, 0);
`endif
    chk("restart_run2", cpu_run, 1);
    peek(4'd0, q); chk("restart_a0", q, 8'h07);
    peek(4'd1, q); chk("restart_a1_cleared", q, 8'h00);

`ifdef CHECKSUM_EN
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h03, 0);
    chk("cs_ok_run", cpu_run, 1);
    chk("cs_ok_done", bus.load_done, 1);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h00, 0);
    chk("cs_bad_err", bus.load_error, 1);
    chk("cs_bad_run", cpu_run, 0);
    chk("cs_bad_done", bus.load_done, 0);
    step(0, 1, 8'h03, 0);
    chk("cs_err_sticky", bus.load_error, 1);
    step(1, 0, 8'h00, 0);
    chk("cs_err_clear", bus.load_error, 0);
`endif

    // Reset in the middle of a load
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h09, 0);
    step(0, 1, 8'h0A, 0);
    reset = 1'b0;
    step(0, 0, 8'h00, 0);
    reset = 1'b1;
    chk("midrst_run", cpu_run, 0);
    chk("midrst_ready", bus.load_ready, 0);
    chk("midrst_done", bus.load_done, 0);
    step(0, 1, 8'h05, 1);
    chk("midrst_idle_ignore", cpu_run, 0);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h05, 1);
`ifdef CHECKSUM_EN
    step(0, 1, 8'h05, 0);
`endif
    peek(4'd0, q); chk("midrst_a0", q, 8'h05);
    peek(4'd1, q); chk("midrst_a1", q, 8'h00);

    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
